// File: rtl/pr_en_pkg.sv
// Shared constants and types for the pr_en registered 4:1 selector.
package pr_en_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

endpackage

// File: rtl/pr_en_mux4.sv
// Purely combinational 4:1 data selector; an unknown select propagates as all-X.
module pr_en_mux4
  import pr_en_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/pr_en.sv
// Registered 4:1 selector with an optional registered priority encoder over a > b > c > d.
// The priority encoder is built only when PR_EN_PRIO_EN is defined; otherwise prio_* are tied to 0.
module pr_en
  import pr_en_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       prio_idx,
  output logic             prio_vld
);

  logic [WIDTH-1:0] mux_p0;

  pr_en_mux4 #(.WIDTH(WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .y   (mux_p0)
  );

  // p0 -> p1: selected data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= mux_p0;
  end

`ifdef PR_EN_PRIO_EN
  // Returns {vld, idx}; all-zero inputs give {0, 0}.
  function automatic logic [2:0] prio_enc(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                          input logic [WIDTH-1:0] vc, input logic [WIDTH-1:0] vd);
    if      (va != '0) prio_enc = 3'b1_00;
    else if (vb != '0) prio_enc = 3'b1_01;
    else if (vc != '0) prio_enc = 3'b1_10;
    else if (vd != '0) prio_enc = 3'b1_11;
    else               prio_enc = 3'b0_00;
  endfunction

  logic [2:0] prio_p0;
  assign prio_p0 = prio_enc(a, b, c, d);

  // p0 -> p1: priority result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_idx <= 2'd0;
      prio_vld <= 1'b0;
    end else begin
      prio_idx <= prio_p0[1:0];
      prio_vld <= prio_p0[2];
    end
  end
`else
  assign prio_idx = 2'd0;
  assign prio_vld = 1'b0;
`endif

endmodule

// File: tb/tb_pr_en.sv
// Self-checking bench for pr_en: vector table, corner sequences and randomized traffic vs a reference model.
module tb_pr_en;

`ifdef PR_EN_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, c, d;
  logic [1:0] sel;
  logic [7:0] out;
  logic [1:0] prio_idx;
  logic       prio_vld;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pr_en #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .sel      (sel),
    .out      (out),
    .prio_idx (prio_idx),
    .prio_vld (prio_vld)
  );

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [1:0] sel;
    logic [7:0] exp_out;
    logic [1:0] exp_idx;
    logic       exp_vld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] va, vb, vc, vd, input logic [1:0] vs);
    a = va; b = vb; c = vc; d = vd; sel = vs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: pick inputs[sel]; priority = first nonzero input scanning a..d.
  function automatic logic [7:0] ref_out(input logic [7:0] v[4], input int s);
    return v[s];
  endfunction

  function automatic logic [2:0] ref_prio(input logic [7:0] v[4]);
    if (!PRIO) return 3'b000;
    for (int i = 0; i < 4; i++)
      if (v[i] != 8'h00) return {1'b1, 2'(i)};
    return 3'b000;
  endfunction

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h24, 8'h81, 8'h09, 8'h63, 2'd0, 8'h24, 2'd0, 1'b1};
    tbl[1] = '{8'h24, 8'h81, 8'h09, 8'h63, 2'd1, 8'h81, 2'd0, 1'b1};
    tbl[2] = '{8'h24, 8'h81, 8'h09, 8'h63, 2'd2, 8'h09, 2'd0, 1'b1};
    tbl[3] = '{8'h24, 8'h81, 8'h09, 8'h63, 2'd3, 8'h63, 2'd0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 8'h09, 8'h63, 2'd3, 8'h63, 2'd2, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0};
    tbl[6] = '{8'h00, 8'h05, 8'h00, 8'h00, 2'd1, 8'h05, 2'd1, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 8'h07, 2'd2, 8'h00, 2'd3, 1'b1};

    rst = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Load a known nonzero value, then assert reset between edges
    drive(8'hFF, 8'h00, 8'h00, 8'h00, 2'd0);
    tick();
    chk("load_ff", out, 8'hFF);
    rst = 1'b1;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_vld", prio_vld, 1'b0);
    chk("async_rst_idx", prio_idx, 2'd0);
    tick();
    chk("held_rst_out", out, 8'h00);
    rst = 1'b0;

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].sel);
      tick();
      chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_idx", i), prio_idx, PRIO ? tbl[i].exp_idx : 2'd0);
      chk($sformatf("tbl%0d_vld", i), prio_vld, PRIO ? tbl[i].exp_vld : 1'b0);
    end

    // Same-edge change of sel and b: only the sampled pair matters, and no comb path to out
    drive(8'h24, 8'h81, 8'h09, 8'h63, 2'd1);
    tick();
    chk("same_edge_pre", out, 8'h81);
    drive(8'h24, 8'h00, 8'h09, 8'h63, 2'd2);
    #1;
    chk("no_comb_path", out, 8'h81);
    tick();
    chk("same_edge_post", out, 8'h09);

    // Mid-stream reset pulse during a sel sweep; pending sample is dropped, sweep resumes
    drive(8'h24, 8'h81, 8'h09, 8'h63, 2'd0);
    tick();
    chk("sweep_s0", out, 8'h24);
    sel = 2'd1;
    tick();
    chk("sweep_s1", out, 8'h81);
    sel = 2'd2;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_vld", prio_vld, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_hold", out, 8'h00);
    tick();
    chk("sweep_resume_s2", out, 8'h09);
    chk("sweep_resume_vld", prio_vld, PRIO);
    sel = 2'd3;
    tick();
    chk("sweep_resume_s3", out, 8'h63);

    // Randomized traffic, zeros biased in to exercise the priority scan
    for (int n = 0; n < 300; n++) begin
      logic [7:0] v[4];
      logic [2:0] ep;
      int s;
      for (int k = 0; k < 4; k++)
        v[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      s = int'($urandom_range(0, 3));
      drive(v[0], v[1], v[2], v[3], 2'(s));
      tick();
      ep = ref_prio(v);
      chk("rand_out", out, ref_out(v, s));
      chk("rand_idx", prio_idx, ep[1:0]);
      chk("rand_vld", prio_vld, ep[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
